// File: rtl/ijtag_pkg.sv
// Shared IJTAG segment definitions: SIB reset value, shift-counter sizing,
// segment strobe bundle and the capture > shift > update operation decode.
package ijtag_pkg;

  localparam logic SIB_RESET = 1'b0;

  typedef struct packed {
    logic select;
    logic capture;
    logic shift;
    logic update;
    logic tdi;
  } seg_strobe_t;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_SHIFT   = 2'd2,
    OP_UPDATE  = 2'd3
  } seg_op_t;

  // Counter must reach DR_WIDTH+2 (saturation value).
  function automatic int shift_cnt_width(input int dr_width);
    return $clog2(dr_width + 3);
  endfunction

  // One operation per cycle; an unselected segment sees no operation at all.
  function automatic seg_op_t decode_op(input seg_strobe_t s);
    seg_op_t op;
    op = OP_IDLE;
    if (s.select) begin
      if (s.capture)     op = OP_CAPTURE;
      else if (s.shift)  op = OP_SHIFT;
      else if (s.update) op = OP_UPDATE;
    end
    return op;
  endfunction

endpackage

// File: rtl/ijtag_sib.sv
// Segment Insertion Bit: shift/update bit pair plus the mux that selects
// between the host segment output and tdi as the SIB shift input.
module ijtag_sib
  import ijtag_pkg::*;
(
  input  logic        TCK,
  input  logic        TRST,
  input  seg_strobe_t strobe,
  input  logic        seg_out,
  input  logic        update_en,
  output logic        sib_shift,
  output logic        sib_upd
);

  seg_op_t op;
  logic    shift_in;

  assign op = decode_op(strobe);

  // Open SIB: the hosted segment sits between tdi and this bit.
  always_comb begin
    shift_in = strobe.tdi;
    if (sib_upd) shift_in = seg_out;
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      sib_shift <= SIB_RESET;
      sib_upd   <= SIB_RESET;
    end else begin
      case (op)
        OP_CAPTURE: sib_shift <= sib_upd;
        OP_SHIFT:   sib_shift <= shift_in;
        OP_UPDATE:  if (update_en) sib_upd <= sib_shift;
        default:    ;
      endcase
    end
  end

endmodule

// File: rtl/ijtag_sib_tdr.sv
// IJTAG segment: one SIB hosting a DR_WIDTH-bit TDR with status capture and a
// control update register. Optional scan-length check under IJTAG_SHIFT_CHECK_EN.
module ijtag_sib_tdr
  import ijtag_pkg::*;
#(
  parameter int                  DR_WIDTH   = 32,
  parameter logic [DR_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                ijtag_select,
  input  logic                ijtag_capture,
  input  logic                ijtag_shift,
  input  logic                ijtag_update,
  input  logic                ijtag_tdi,
  output logic                ijtag_tdo,
  input  logic [DR_WIDTH-1:0] instr_status,
  output logic [DR_WIDTH-1:0] instr_ctrl,
  output logic                instr_ctrl_valid,
  output logic                sib_open,
  output logic                len_err
);

  seg_strobe_t         strobe;
  seg_op_t             op;
  logic                sib_shift;
  logic                sib_upd;
  logic                len_ok;
  logic                ctrl_write;
  logic [DR_WIDTH-1:0] tdr_shift;
  logic [DR_WIDTH-1:0] tdr_shifted;

  assign strobe = '{select:  ijtag_select,
                    capture: ijtag_capture,
                    shift:   ijtag_shift,
                    update:  ijtag_update,
                    tdi:     ijtag_tdi};
  assign op     = decode_op(strobe);

  ijtag_sib u_sib (
    .TCK       (TCK),
    .TRST      (TRST),
    .strobe    (strobe),
    .seg_out   (tdr_shift[0]),
    .update_en (len_ok),
    .sib_shift (sib_shift),
    .sib_upd   (sib_upd)
  );

  assign ijtag_tdo = sib_shift;
  assign sib_open  = sib_upd;

  if (DR_WIDTH == 1) begin : g_tdr_w1
    assign tdr_shifted = ijtag_tdi;
  end else begin : g_tdr_wn
    assign tdr_shifted = {ijtag_tdi, tdr_shift[DR_WIDTH-1:1]};
  end

  // The TDR only moves while it is in the scan path.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      tdr_shift <= '0;
    end else if (sib_upd) begin
      if (op == OP_CAPTURE)    tdr_shift <= instr_status;
      else if (op == OP_SHIFT) tdr_shift <= tdr_shifted;
    end
  end

  assign ctrl_write = (op == OP_UPDATE) && len_ok && sib_upd;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      instr_ctrl       <= CTRL_RESET;
      instr_ctrl_valid <= 1'b0;
    end else begin
      instr_ctrl_valid <= ctrl_write;
      if (ctrl_write) instr_ctrl <= tdr_shift;
    end
  end

`ifdef IJTAG_SHIFT_CHECK_EN
  localparam int            CW         = shift_cnt_width(DR_WIDTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_OPEN   = CW'(DR_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DR_WIDTH + 2);

  logic [CW-1:0] shift_cnt;
  logic          len_err_q;

  // Saturation keeps any over-length scan distinguishable from a correct one.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      shift_cnt <= '0;
    end else if (op == OP_CAPTURE) begin
      shift_cnt <= '0;
    end else if (op == OP_SHIFT && shift_cnt != CNT_MAX) begin
      shift_cnt <= shift_cnt + CNT_ONE;
    end
  end

  assign len_ok = (shift_cnt == (sib_upd ? CNT_OPEN : CNT_ONE));

  always_ff @(posedge TCK) begin
    if (TRST) begin
      len_err_q <= 1'b0;
    end else if (op == OP_UPDATE && !len_ok) begin
      len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_ok  = 1'b1;
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_ijtag_sib_tdr.sv
// Bench for ijtag_sib_tdr (DR_WIDTH=8): directed scans plus random strobes,
// checked every cycle against a path-level model of the segment.
module tb_ijtag_sib_tdr;

  localparam int W = 8;
`ifdef IJTAG_SHIFT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic         TCK = 1'b0;
  logic         TRST = 1'b1;
  logic         ijtag_select = 1'b0;
  logic         ijtag_capture = 1'b0;
  logic         ijtag_shift = 1'b0;
  logic         ijtag_update = 1'b0;
  logic         ijtag_tdi = 1'b0;
  logic         ijtag_tdo;
  logic [W-1:0] instr_status = '0;
  logic [W-1:0] instr_ctrl;
  logic         instr_ctrl_valid;
  logic         sib_open;
  logic         len_err;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  ijtag_sib_tdr #(.DR_WIDTH(W), .CTRL_RESET(8'h00)) dut (
    .TCK              (TCK),
    .TRST             (TRST),
    .ijtag_select     (ijtag_select),
    .ijtag_capture    (ijtag_capture),
    .ijtag_shift      (ijtag_shift),
    .ijtag_update     (ijtag_update),
    .ijtag_tdi        (ijtag_tdi),
    .ijtag_tdo        (ijtag_tdo),
    .instr_status     (instr_status),
    .instr_ctrl       (instr_ctrl),
    .instr_ctrl_valid (instr_ctrl_valid),
    .sib_open         (sib_open),
    .len_err          (len_err)
  );

  always #5 TCK = ~TCK;

  // Model: the scan path as one number {tdr, sib}, shifted right with tdi at the top.
  logic [W-1:0] m_tdr = '0;
  logic         m_sib = 1'b0;
  logic         m_upd = 1'b0;
  logic [W-1:0] m_ctrl = '0;
  logic         m_valid = 1'b0;
  logic         m_err = 1'b0;
  int           m_cnt = 0;

  always @(posedge TCK) begin
    logic [W:0] path;
    bit         ok;
    m_valid = 1'b0;
    if (TRST) begin
      m_tdr = '0; m_sib = 1'b0; m_upd = 1'b0; m_ctrl = '0; m_err = 1'b0; m_cnt = 0;
    end else if (ijtag_select) begin
      if (ijtag_capture) begin
        m_sib = m_upd;
        if (m_upd) m_tdr = instr_status;
        m_cnt = 0;
      end else if (ijtag_shift) begin
        m_cnt = m_cnt + 1;
        if (m_upd) begin
          path = {m_tdr, m_sib};
          path = (path >> 1) | ((W+1)'(ijtag_tdi) << W);
          m_tdr = path[W:1];
          m_sib = path[0];
        end else begin
          m_sib = ijtag_tdi;
        end
      end else if (ijtag_update) begin
        ok = !CHECK_EN || (m_cnt == (m_upd ? W + 1 : 1));
        if (!ok) begin
          m_err = 1'b1;
        end else begin
          if (m_upd) begin
            m_ctrl  = m_tdr;
            m_valid = 1'b1;
          end
          m_upd = m_sib;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge TCK) begin
    if (chk_en) begin
      check("tdo", 32'(ijtag_tdo), 32'(m_sib));
      check("sib_open", 32'(sib_open), 32'(m_upd));
      check("instr_ctrl", 32'(instr_ctrl), 32'(m_ctrl));
      check("ctrl_valid", 32'(instr_ctrl_valid), 32'(m_valid));
      check("len_err", 32'(len_err), 32'(m_err));
    end
  end

  task automatic step(input logic rst, input logic sel, input logic cap, input logic sh,
                      input logic upd, input logic tdi, output logic tdo_now);
    @(negedge TCK);
    TRST          = rst;
    ijtag_select  = sel;
    ijtag_capture = cap;
    ijtag_shift   = sh;
    ijtag_update  = upd;
    ijtag_tdi     = tdi;
    tdo_now       = ijtag_tdo;
  endtask

  task automatic idle();
    logic t;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic scan(input logic do_cap, input int n, input logic [15:0] bits,
                      input logic do_upd, output logic [15:0] tdo_bits);
    logic t;
    tdo_bits = '0;
    if (do_cap) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, bits[i], t);
      tdo_bits[i] = t;
    end
    if (do_upd) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, t);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
  endtask

  initial begin
    logic [15:0] tb;
    logic        t;

    // Reset
    TRST = 1'b1;
    @(posedge TCK);
    @(negedge TCK);
    chk_en = 1'b1;
    check("rst_ctrl", 32'(instr_ctrl), 32'h00);
    check("rst_sib_open", 32'(sib_open), 32'h0);
    check("rst_valid", 32'(instr_ctrl_valid), 32'h0);
    check("rst_tdo", 32'(ijtag_tdo), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    idle();

    // Open the SIB with a 1-bit scan
    scan(1'b1, 1, 16'h0001, 1'b1, tb);
    check("open_tdo", 32'(tb[0]), 32'h0);
    check("open_sib_open", 32'(sib_open), 32'h1);
    check("open_ctrl", 32'(instr_ctrl), 32'h00);
    check("open_valid", 32'(instr_ctrl_valid), 32'h0);

    // Full 9-bit scan, then back-to-back updates
    instr_status = 8'hA5;
    scan(1'b1, 9, 16'h0079, 1'b0, tb);
    check("scan9_tdo", 32'(tb[8:0]), 32'h14B);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, t);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, t);
    check("upd1_ctrl", 32'(instr_ctrl), 32'h3C);
    check("upd1_valid", 32'(instr_ctrl_valid), 32'h1);
    idle();
    check("upd2_valid", 32'(instr_ctrl_valid), 32'h1);
    idle();
    check("upd_valid_low", 32'(instr_ctrl_valid), 32'h0);
    check("upd_sib_open", 32'(sib_open), 32'h1);

    // Close the SIB while writing 0xDA
    instr_status = 8'h33;
    scan(1'b1, 9, 16'h01B4, 1'b1, tb);
    check("close_ctrl", 32'(instr_ctrl), 32'hDA);
    check("close_valid", 32'(instr_ctrl_valid), 32'h1);
    check("close_sib_open", 32'(sib_open), 32'h0);

    // 1-bit scan reopens; no pulse since SIB was closed
    scan(1'b1, 1, 16'h0001, 1'b1, tb);
    check("reopen_tdo", 32'(tb[0]), 32'h0);
    check("reopen_sib_open", 32'(sib_open), 32'h1);
    check("reopen_valid", 32'(instr_ctrl_valid), 32'h0);
    check("reopen_ctrl", 32'(instr_ctrl), 32'hDA);

    // 8 shifts without capture expose the held TDR (count 1+8 is a legal length)
    scan(1'b0, 8, 16'h0096, 1'b1, tb);
    check("hold_tdo", 32'(tb[7:0]), 32'hB5);
    check("hold_ctrl", 32'(instr_ctrl), 32'h96);

    // Short scan (7 shifts)
    instr_status = 8'h40 | 8'($urandom_range(0, 255));
    scan(1'b1, 7, 16'($urandom_range(0, 127)), 1'b1, tb);
    check("short_len_err", 32'(len_err), 32'(CHECK_EN));
    check("short_valid", 32'(instr_ctrl_valid), CHECK_EN ? 32'h0 : 32'h1);
    check("short_sib_open", 32'(sib_open), 32'h1);
    check("short_ctrl", 32'(instr_ctrl), CHECK_EN ? 32'h96 : 32'(m_ctrl));

    // A correct scan afterwards applies but the error stays set
    scan(1'b1, 9, 16'h0023, 1'b1, tb);
    check("after_ctrl", 32'(instr_ctrl), 32'h11);
    check("after_len_err", 32'(len_err), 32'(CHECK_EN));

    // Strobes with select low
    for (int i = 0; i < 20; i++) begin
      instr_status = 8'($urandom_range(0, 255));
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
    end
    idle();
    check("nosel_ctrl", 32'(instr_ctrl), 32'h11);
    check("nosel_sib_open", 32'(sib_open), 32'h1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      instr_status = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: scan(1'b1, m_upd ? W + 1 : 1, 16'($urandom_range(0, 65535)), 1'b1, tb);
        1: scan(1'b1, $urandom_range(0, 11), 16'($urandom_range(0, 65535)),
                1'($urandom_range(0, 1)), tb);
        2: step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
        default: step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
      endcase
    end

    // Make sure SIB is open with data, then reset in the middle of a shift
    scan(1'b1, 1, 16'h0001, 1'b1, tb);
    instr_status = 8'hFF;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t);
    idle();
    check("trst_ctrl", 32'(instr_ctrl), 32'h00);
    check("trst_sib_open", 32'(sib_open), 32'h0);
    check("trst_len_err", 32'(len_err), 32'h0);
    check("trst_valid", 32'(instr_ctrl_valid), 32'h0);
    check("trst_tdo", 32'(ijtag_tdo), 32'h0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ijtag_sib_tdr.md
# ijtag_sib_tdr

IJTAG instrument segment that sits directly downstream of the JTAG TAP controller on its IJTAG interface, consuming select/capture/shift/update/tdi and returning ijtag_tdo. It contains one Segment Insertion Bit (SIB) that switches a DR_WIDTH-bit Test Data Register (TDR) into or out of the scan path. The TDR captures instrument status and, on update, drives a control word plus a one-cycle valid pulse to the instrument.

## Interface
- DR_WIDTH, 32: TDR length in bits; minimum 1.
- CTRL_RESET, '0: reset value of instr_ctrl.
- TCK  in  1  test clock; all state on posedge.
- TRST  in  1  reset, synchronous, active-high.
- ijtag_select  in  1  segment selected; qualifies capture/shift/update.
- ijtag_capture  in  1  capture strobe (CAPTURE_DR).
- ijtag_shift  in  1  shift enable (SHIFT_DR).
- ijtag_update  in  1  update strobe (UPDATE_DR).
- ijtag_tdi  in  1  scan data in.
- ijtag_tdo  out  1  scan data out.
- instr_status  in  DR_WIDTH  instrument status, sampled at capture.
- instr_ctrl  out  DR_WIDTH  instrument control word (update register).
- instr_ctrl_valid  out  1  one-cycle pulse when instr_ctrl is written.
- sib_open  out  1  SIB update bit; 1 = TDR in scan path.
- len_err  out  1  sticky scan-length error (see Configuration).

## Operation
- Registers: sib_shift, sib_upd, tdr_shift[DR_WIDTH-1:0], instr_ctrl, instr_ctrl_valid, (len_err, shift_cnt).
- Reset (TRST=1 at posedge): sib_shift=0, sib_upd=0, tdr_shift=0, instr_ctrl=CTRL_RESET, instr_ctrl_valid=0, len_err=0, shift_cnt=0.
- Operations act only when ijtag_select=1; priority capture > shift > update if several strobes are high.
- Capture: sib_shift <= sib_upd; if sib_upd=1, tdr_shift <= instr_status; otherwise tdr_shift holds.
- Shift, SIB open (sib_upd=1): ijtag_tdi -> tdr_shift[DR_WIDTH-1] ... tdr_shift[0] -> sib_shift -> ijtag_tdo. Path length is DR_WIDTH+1.
- Shift, SIB closed: ijtag_tdi -> sib_shift -> ijtag_tdo. tdr_shift holds. Path length is 1.
- Update: the decision uses sib_upd before the edge (the path used during the scan).
  - If sib_upd was 1: instr_ctrl <= tdr_shift and instr_ctrl_valid pulses.
  - Then sib_upd <= sib_shift. Opening or closing takes effect for the next scan.
- ijtag_tdo = sib_shift, combinational from registers only; no combinational path from ijtag_tdi.
- Strobes with ijtag_select=0 are ignored, and all state holds.

## Timing
- First shifted-out bit is the captured sib_upd, valid during the whole first SHIFT_DR cycle.
- ijtag_tdo changes only after a posedge where shift or capture was active.
- instr_ctrl changes at the posedge sampling ijtag_update=1.
- instr_ctrl_valid is high for exactly the following cycle, then 0.
- An update with the SIB closed produces no valid pulse.
- Back-to-back updates on consecutive cycles each produce their own pulse, so valid stays high for 2 cycles.
- TRST mid-scan returns all state to reset values at that edge and closes the SIB; no update occurs.

## Configuration
- IJTAG_SHIFT_CHECK_EN defined:
  - shift_cnt counts qualified shift cycles since the last capture, saturating at DR_WIDTH+2; it is cleared on capture.
  - Expected count at update: DR_WIDTH+1 if sib_upd=1, otherwise 1.
  - On mismatch:
    - instr_ctrl and sib_upd hold.
    - No valid pulse.
    - len_err <= 1 (sticky until TRST).
- IJTAG_SHIFT_CHECK_EN undefined: no counter; len_err tied 0; every update applies.

## Structure
- Shared package ijtag_pkg: SIB reset constant, shift-count width function ($clog2(DR_WIDTH+3)), and a segment-strobe struct {select, capture, shift, update, tdi} for reuse by future segments.
- Sub-module ijtag_sib: the SIB bit pair (sib_shift/sib_upd) with capture/shift/update and the select-path mux. The top-level block instantiates ijtag_sib once and adds the TDR, update register, and length check.

## Test plan
All scenarios use DR_WIDTH=8 with IJTAG_SHIFT_CHECK_EN defined.
- Reset, then 1 capture, 1 shift (tdi=1), 1 update -> sib_open=1; instr_ctrl unchanged (0x00); no valid pulse; ijtag_tdo=0 during the shift.
- SIB open, instr_status=0xA5, then capture and 9 shifts of tdi pattern {1, 0x3C LSB-first} -> tdo shows 1 then 0xA5 LSB-first.
  - Then update -> instr_ctrl=0x3C, valid for 1 cycle, sib_open stays 1.
- SIB open, capture, 9 shifts with last (SIB) bit 0, then update -> instr_ctrl written and sib_open=0.
  - Next scan is 1 bit long; the TDR holds its contents.
- SIB open, capture, 7 shifts, update -> len_err=1; instr_ctrl and sib_open unchanged; no pulse.
  - len_err stays 1 after later correct scans.
- Strobes with ijtag_select=0 -> no state change.
- TRST asserted during shift -> all outputs at reset values the next cycle (instr_ctrl=CTRL_RESET).
